// File: rtl/sigma_pkg.sv
// Shared definitions for the Sigma-style microcoded core: sequencer and ALU codes,
// microword field positions, opcodes and the microcode image builder.
package sigma_pkg;

    localparam int UC_DEPTH = 256;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_DISPATCH = 3'd2,
        SEQ_JZ       = 3'd3,
        SEQ_END      = 3'd4
    } seq_e;

    typedef enum logic [2:0] {
        ALU_B    = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_A    = 3'd6,
        ALU_ZERO = 3'd7
    } alu_e;

    // Microword bit positions, bit 0 is the MSB.
    localparam int UW_SEQ_LO   = 0;
    localparam int UW_SEQ_HI   = 2;
    localparam int UW_ADDR_SEL = 3;
    localparam int UW_LD_IR    = 5;
    localparam int UW_INC_Q    = 6;
    localparam int UW_LD_Q     = 7;
    localparam int UW_ALU_LO   = 8;
    localparam int UW_ALU_HI   = 10;
    localparam int UW_BSEL     = 11;
    localparam int UW_WR_R     = 12;
    localparam int UW_ENDE     = 13;
    localparam int UW_TGT_LO   = 16;
    localparam int UW_TGT_HI   = 23;

    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_WAIT = 7'h2E;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_B    = 7'h68;

    function automatic logic [0:31] uword(
        input seq_e       seq,
        input logic       addr_sel,
        input logic       ld_ir,
        input logic       inc_q,
        input logic       ld_q,
        input alu_e       alu,
        input logic       bsel,
        input logic       wr_r,
        input logic       ende,
        input logic [7:0] target
    );
        logic [0:31] w;
        w = '0;
        w[UW_SEQ_LO:UW_SEQ_HI] = seq;
        w[UW_ADDR_SEL]         = addr_sel;
        w[UW_LD_IR]            = ld_ir;
        w[UW_INC_Q]            = inc_q;
        w[UW_LD_Q]             = ld_q;
        w[UW_ALU_LO:UW_ALU_HI] = alu;
        w[UW_BSEL]             = bsel;
        w[UW_WR_R]             = wr_r;
        w[UW_ENDE]             = ende;
        w[UW_TGT_LO:UW_TGT_HI] = target;
        return w;
    endfunction

    // Word 0 fetches; 128+opcode holds each instruction's execute step.
    function automatic logic [0:31] uc_image(input logic [7:0] addr);
        logic [0:31] w;
        w = '0;
        if (addr == 8'd0) begin
            w = uword(SEQ_DISPATCH, 1'b0, 1'b1, 1'b1, 1'b0, ALU_B, 1'b0, 1'b0, 1'b0, 8'd0);
        end else if (addr[7]) begin
            case (addr[6:0])
                OP_LI:   w = uword(SEQ_END, 1'b0, 1'b0, 1'b0, 1'b0, ALU_B, 1'b1, 1'b1, 1'b1, 8'd0);
                OP_AI:   w = uword(SEQ_END, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b1, 8'd0);
                OP_LW:   w = uword(SEQ_END, 1'b1, 1'b0, 1'b0, 1'b0, ALU_B, 1'b0, 1'b1, 1'b1, 8'd0);
                OP_AW:   w = uword(SEQ_END, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b1, 8'd0);
                OP_B:    w = uword(SEQ_END, 1'b1, 1'b0, 1'b0, 1'b1, ALU_ZERO, 1'b0, 1'b0, 1'b1, 8'd0);
                OP_WAIT: w = uword(SEQ_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ZERO, 1'b0, 1'b0, 1'b0, addr);
                default: w = uword(SEQ_END, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ZERO, 1'b0, 1'b0, 1'b1, 8'd0);
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/sigma_cpu_uc_rom.sv
// 256x32 microcode ROM with asynchronous read. Contents are elaborated from the
// package image so opcode definitions and microcode stay in one place.
module uc_rom
    import sigma_pkg::*;
(
    input  logic [7:0]  upc,
    output logic [0:31] uw
);

    logic [0:31] memory [0:UC_DEPTH-1];

    generate
        for (genvar gi = 0; gi < UC_DEPTH; gi++) begin : g_image
            assign memory[gi] = uc_image(8'(gi));
        end
    endgenerate

    assign uw = memory[upc];

endmodule

// File: rtl/sigma_cpu.sv
// Microcoded Sigma-style 32-bit core: instruction register, register file,
// EA adder, ALU and microsequencer driven by the uc_rom microword.
module sigma_cpu
    import sigma_pkg::*;
#(
    parameter logic [15:31] RESET_PC = 17'd0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [0:31]  data_in,
    output logic [15:31] address
);

    logic [15:31] q;
    logic [1:7]   o;
    logic [8:11]  r;
    logic [12:14] x;
    logic [15:31] p;
    logic [0:31]  rr [0:15];
    logic [7:0]   upc;
    logic [7:0]   upc_next;
    logic [0:31]  uw;

    logic [2:0]   seq;
    logic         addr_sel;
    logic         ld_ir;
    logic         inc_q;
    logic         ld_q;
    alu_e         alu_op;
    logic         bsel;
    logic         wr_r;
    logic         ende;
    logic [7:0]   target;

    logic [15:31] index_val;
    logic [15:31] ea;
    logic [0:31]  operand_a;
    logic [0:31]  operand_b;
    logic [0:31]  alu_out;
    logic [1:7]   dispatch_op;
    logic         unused_bits;

    uc_rom uc_rom (
        .upc (upc),
        .uw  (uw)
    );

    assign seq      = uw[UW_SEQ_LO:UW_SEQ_HI];
    assign addr_sel = uw[UW_ADDR_SEL];
    assign ld_ir    = uw[UW_LD_IR];
    assign inc_q    = uw[UW_INC_Q];
    assign ld_q     = uw[UW_LD_Q];
    assign alu_op   = alu_e'(uw[UW_ALU_LO:UW_ALU_HI]);
    assign bsel     = uw[UW_BSEL];
    assign wr_r     = uw[UW_WR_R];
    assign ende     = uw[UW_ENDE];
    assign target   = uw[UW_TGT_LO:UW_TGT_HI];

    // Reserved microword bits and the indirect flag carry no function.
    assign unused_bits = ^{uw[4], uw[14:15], uw[24:31], data_in[0]};

    always_comb begin
        index_val = '0;
        if (x != 3'd0) begin
            index_val = rr[x][15:31];
        end
        ea        = p + index_val;
        address   = addr_sel ? ea : q;
        operand_a = rr[r];
        operand_b = bsel ? {{12{x[12]}}, x, p} : data_in;
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_B:    alu_out = operand_b;
            ALU_ADD:  alu_out = operand_a + operand_b;
            ALU_SUB:  alu_out = operand_a - operand_b;
            ALU_AND:  alu_out = operand_a & operand_b;
            ALU_OR:   alu_out = operand_a | operand_b;
            ALU_XOR:  alu_out = operand_a ^ operand_b;
            ALU_A:    alu_out = operand_a;
            default:  alu_out = '0;
        endcase
    end

    // The fetch word loads o and dispatches together, so dispatch on the incoming opcode.
    assign dispatch_op = ld_ir ? data_in[1:7] : o;

    always_comb begin
        upc_next = upc + 8'd1;
        case (seq)
            SEQ_JUMP:     upc_next = target;
            SEQ_DISPATCH: upc_next = {1'b1, dispatch_op};
            SEQ_JZ:       upc_next = (alu_out == 32'd0) ? target : upc + 8'd1;
            SEQ_END:      upc_next = 8'd0;
            default:      upc_next = upc + 8'd1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q   <= RESET_PC;
            upc <= 8'd0;
            o   <= '0;
            r   <= '0;
            x   <= '0;
            p   <= '0;
            for (int i = 0; i < 16; i++) begin
                rr[i] <= '0;
            end
        end else begin
            upc <= upc_next;
            if (ld_ir) begin
                o <= data_in[1:7];
                r <= data_in[8:11];
                x <= data_in[12:14];
                p <= data_in[15:31];
            end
            if (ld_q) begin
                q <= ea;
            end else if (inc_q) begin
                q <= q + 17'd1;
            end
            if (wr_r) begin
                rr[r] <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: small programs in a combinational memory model,
// checked against hand-computed register, PC and strobe values.
module tb_sigma_cpu;

    logic         clock;
    logic         reset;
    logic [0:31]  data_in;
    logic [15:31] address;
    logic [0:31]  mem [0:255];

    int checks;
    int errors;
    int ende_cnt;
    int base;

    localparam logic [0:31] I_WAIT = 32'h2E00_0000;

    sigma_cpu dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .address (address)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb data_in = mem[address[24:31]];

    always @(negedge clock) begin
        if (!reset && dut.ende) ende_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [0:31] w0, input logic [0:31] w1, input logic [0:31] w2);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic run_to_wait(input string tag, input int budget);
        int n;
        n = 0;
        while (dut.o != 7'h2E && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(dut.o), 32'h2E);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ende_cnt = 0;
        reset    = 1'b1;
        load(I_WAIT, 32'h0, 32'h0);

        // Reset state, then WAIT at word 0.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_o", 32'(dut.o), 32'h0);
        check("rst_q", 32'(dut.q), 32'h0);
        check("rst_ende", 32'(dut.ende), 32'h0);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_rr1", dut.rr[1], 32'h0);
        @(posedge clock); #1 reset = 1'b0;
        base = ende_cnt;
        @(posedge clock);
        @(posedge clock); #1;
        check("wait_o", 32'(dut.o), 32'h2E);
        repeat (4) @(negedge clock);
        check("wait_q", 32'(dut.q), 32'h1);
        check("wait_o_held", 32'(dut.o), 32'h2E);
        check("wait_ende_cnt", 32'(ende_cnt - base), 32'h0);

        // LI R1,5; LI R2,-3; WAIT
        load(32'h2210_0005, 32'h222F_FFFD, I_WAIT);
        do_reset();
        base = ende_cnt;
        @(negedge clock); check("li_c1_ende", 32'(dut.ende), 32'h0);
        @(negedge clock); check("li_c2_ende", 32'(dut.ende), 32'h1);
        @(negedge clock); check("li_c3_ende", 32'(dut.ende), 32'h0);
        @(negedge clock); check("li_c4_ende", 32'(dut.ende), 32'h1);
        @(negedge clock); check("li_c5_addr", 32'(address), 32'h2);
        @(negedge clock); check("li_c6_o", 32'(dut.o), 32'h2E);
        check("li_rr1", dut.rr[1], 32'h5);
        check("li_rr2", dut.rr[2], 32'hFFFF_FFFD);
        check("li_ende_cnt", 32'(ende_cnt - base), 32'h2);

        // LW R3,0x40; AW R3,0x40
        load(32'h3230_0040, 32'h3030_0040, I_WAIT);
        mem[8'h40] = 32'h1234_5678;
        do_reset();
        @(negedge clock); check("lw_fetch_addr", 32'(address), 32'h0);
        @(negedge clock); check("lw_exec_addr", 32'(address), 32'h40);
        @(negedge clock); check("aw_fetch_addr", 32'(address), 32'h1);
        @(negedge clock); check("aw_exec_addr", 32'(address), 32'h40);
        run_to_wait("aw_reach_wait", 10);
        check("aw_rr3", dut.rr[3], 32'h2468_ACF0);

        // LI R4,0x10; LW R5,0x30,X4
        load(32'h2240_0010, 32'h3258_0030, I_WAIT);
        mem[8'h40] = 32'h7;
        do_reset();
        repeat (4) @(negedge clock);
        check("idx_ea_addr", 32'(address), 32'h40);
        run_to_wait("idx_reach_wait", 10);
        check("idx_rr4", dut.rr[4], 32'h10);
        check("idx_rr5", dut.rr[5], 32'h7);

        // B 0x10 skips LI R1,9
        load(32'h6800_0010, 32'h2210_0009, 32'h0);
        mem[8'h10] = I_WAIT;
        do_reset();
        repeat (3) @(negedge clock);
        check("b_target_addr", 32'(address), 32'h10);
        run_to_wait("b_reach_wait", 10);
        repeat (2) @(negedge clock);
        check("b_rr1", dut.rr[1], 32'h0);
        check("b_q", 32'(dut.q), 32'h11);

        // Reset during the LI execute cycle, then rerun.
        load(32'h2210_0005, 32'h222F_FFFD, I_WAIT);
        do_reset();
        @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rr1", dut.rr[1], 32'h0);
        check("mid_q", 32'(dut.q), 32'h0);
        check("mid_upc", 32'(dut.upc), 32'h0);
        reset = 1'b0;
        base = ende_cnt;
        run_to_wait("mid_reach_wait", 20);
        check("mid_rr1_rerun", dut.rr[1], 32'h5);
        check("mid_rr2_rerun", dut.rr[2], 32'hFFFF_FFFD);
        check("mid_q_rerun", 32'(dut.q), 32'h3);
        check("mid_ende_cnt", 32'(ende_cnt - base), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
